// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, EX-stage operand
// forwarding from EX/MEM and MEM/WB, and a saturating bubble counter.
module id_ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_pc,
    input  logic [WIDTH-1:0] d_rs1_data,
    input  logic [WIDTH-1:0] d_rs2_data,
    input  logic [WIDTH-1:0] d_imm,
    input  logic [4:0]       d_rs1,
    input  logic [4:0]       d_rs2,
    input  logic [4:0]       d_rd,
    input  logic [3:0]       d_alu_cntrl,
    input  logic             d_alu_src_b,
    input  logic             d_reg_write,
    input  logic             d_mem_write,
    input  logic [1:0]       d_result_src,
    input  logic             flush,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [WIDTH-1:0] mem_result,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic [WIDTH-1:0] wb_result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       ex_alu_cntrl,
    output logic             ex_valid,
    output logic             ex_reg_write,
    output logic             ex_mem_write,
    output logic [1:0]       ex_result_src,
    output logic [4:0]       ex_rd,
    output logic [WIDTH-1:0] ex_pc,
    output logic [WIDTH-1:0] ex_store_data,
    output logic             stall_o,
    output logic [15:0]      perf_bubbles
);

    localparam logic [1:0] RES_LOAD = 2'b01;

    logic             vld_p1;
    logic [WIDTH-1:0] pc_p1;
    logic [WIDTH-1:0] rs1_data_p1;
    logic [WIDTH-1:0] rs2_data_p1;
    logic [WIDTH-1:0] imm_p1;
    logic [4:0]       rs1_p1;
    logic [4:0]       rs2_p1;
    logic [4:0]       rd_p1;
    logic [3:0]       alu_cntrl_p1;
    logic             alu_src_b_p1;
    logic             reg_write_p1;
    logic             mem_write_p1;
    logic [1:0]       result_src_p1;
    logic [15:0]      bubble_cnt_p1;

    logic             load_use;
    logic             bubble;
    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Youngest producer wins; x0 is hard-wired zero and never forwarded.
    function automatic logic [WIDTH-1:0] fwd_sel(
        input logic [4:0]       idx,
        input logic [WIDTH-1:0] reg_val,
        input logic [4:0]       m_rd,
        input logic             m_we,
        input logic [WIDTH-1:0] m_res,
        input logic [4:0]       w_rd,
        input logic             w_we,
        input logic [WIDTH-1:0] w_res
    );
        if (m_we && (m_rd != 5'd0) && (m_rd == idx)) begin
            return m_res;
        end else if (w_we && (w_rd != 5'd0) && (w_rd == idx)) begin
            return w_res;
        end
        return reg_val;
    endfunction

    // rs2 is compared even when the decoded instruction uses an immediate.
    always_comb begin
        load_use = ~flush & d_valid & vld_p1 & reg_write_p1
                 & (result_src_p1 == RES_LOAD) & (rd_p1 != 5'd0)
                 & ((rd_p1 == d_rs1) | (rd_p1 == d_rs2));
    end

    assign bubble  = flush | load_use;
    assign stall_o = load_use;

    // ---- ID -> EX boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1        <= 1'b0;
            pc_p1         <= '0;
            rs1_data_p1   <= '0;
            rs2_data_p1   <= '0;
            imm_p1        <= '0;
            rs1_p1        <= '0;
            rs2_p1        <= '0;
            rd_p1         <= '0;
            alu_cntrl_p1  <= '0;
            alu_src_b_p1  <= 1'b0;
            reg_write_p1  <= 1'b0;
            mem_write_p1  <= 1'b0;
            result_src_p1 <= '0;
        end else if (bubble) begin
            vld_p1        <= 1'b0;
            pc_p1         <= '0;
            rs1_data_p1   <= '0;
            rs2_data_p1   <= '0;
            imm_p1        <= '0;
            rs1_p1        <= '0;
            rs2_p1        <= '0;
            rd_p1         <= '0;
            alu_cntrl_p1  <= '0;
            alu_src_b_p1  <= 1'b0;
            reg_write_p1  <= 1'b0;
            mem_write_p1  <= 1'b0;
            result_src_p1 <= '0;
        end else begin
            vld_p1        <= d_valid;
            pc_p1         <= d_pc;
            rs1_data_p1   <= d_rs1_data;
            rs2_data_p1   <= d_rs2_data;
            imm_p1        <= d_imm;
            rs1_p1        <= d_rs1;
            rs2_p1        <= d_rs2;
            rd_p1         <= d_rd;
            alu_cntrl_p1  <= d_valid ? d_alu_cntrl : 4'd0;
            alu_src_b_p1  <= d_valid & d_alu_src_b;
            reg_write_p1  <= d_valid & d_reg_write;
            mem_write_p1  <= d_valid & d_mem_write;
            result_src_p1 <= d_valid ? d_result_src : 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_p1 <= '0;
        end else if (load_use) begin
            bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
        end
    end

    // ---- EX operand selection (combinational) ----
    always_comb begin
        fwd_a = fwd_sel(rs1_p1, rs1_data_p1, mem_rd, mem_reg_write, mem_result,
                        wb_rd, wb_reg_write, wb_result);
        fwd_b = fwd_sel(rs2_p1, rs2_data_p1, mem_rd, mem_reg_write, mem_result,
                        wb_rd, wb_reg_write, wb_result);
    end

    assign alu_a         = fwd_a;
    assign alu_b         = alu_src_b_p1 ? imm_p1 : fwd_b;
    assign ex_store_data = fwd_b;
    assign ex_alu_cntrl  = alu_cntrl_p1;
    assign ex_valid      = vld_p1;
    assign ex_reg_write  = reg_write_p1;
    assign ex_mem_write  = mem_write_p1;
    assign ex_result_src = result_src_p1;
    assign ex_rd         = rd_p1;
    assign ex_pc         = pc_p1;
    assign perf_bubbles  = bubble_cnt_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed literal checks plus
// randomized traffic compared every cycle against a behavioural model.
module tb_id_ex_stage;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         d_valid;
    logic [W-1:0] d_pc, d_rs1_data, d_rs2_data, d_imm;
    logic [4:0]   d_rs1, d_rs2, d_rd;
    logic [3:0]   d_alu_cntrl;
    logic         d_alu_src_b, d_reg_write, d_mem_write;
    logic [1:0]   d_result_src;
    logic         flush;
    logic [4:0]   mem_rd, wb_rd;
    logic         mem_reg_write, wb_reg_write;
    logic [W-1:0] mem_result, wb_result;
    logic [W-1:0] alu_a, alu_b, ex_pc, ex_store_data;
    logic [3:0]   ex_alu_cntrl;
    logic         ex_valid, ex_reg_write, ex_mem_write, stall_o;
    logic [1:0]   ex_result_src;
    logic [4:0]   ex_rd;
    logic [15:0]  perf_bubbles;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    id_ex_stage #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_pc(d_pc),
        .d_rs1_data(d_rs1_data), .d_rs2_data(d_rs2_data), .d_imm(d_imm),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd), .d_alu_cntrl(d_alu_cntrl),
        .d_alu_src_b(d_alu_src_b), .d_reg_write(d_reg_write),
        .d_mem_write(d_mem_write), .d_result_src(d_result_src), .flush(flush),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .alu_a(alu_a), .alu_b(alu_b), .ex_alu_cntrl(ex_alu_cntrl),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_write(ex_mem_write), .ex_result_src(ex_result_src),
        .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_store_data(ex_store_data),
        .stall_o(stall_o), .perf_bubbles(perf_bubbles)
    );

    always #5 clk = ~clk;

    // Behavioural model of the EX-side instruction slot.
    typedef struct packed {
        logic         v;
        logic [W-1:0] pc, r1d, r2d, imm;
        logic [4:0]   rs1, rs2, rd;
        logic [3:0]   alu;
        logic         srcb, rw, mw;
        logic [1:0]   rsrc;
    } ex_t;

    ex_t         m;
    logic [15:0] m_cnt;
    logic        preload_req = 1'b0;
    logic [15:0] preload_val = 16'h0;
    logic        chk_en = 1'b0;

    function automatic logic m_stall();
        return !flush && d_valid && m.v && m.rw && (m.rsrc == 2'b01) &&
               (m.rd != 5'd0) && ((m.rd == d_rs1) || (m.rd == d_rs2));
    endfunction

    function automatic logic [W-1:0] exp_fwd(logic [4:0] idx, logic [W-1:0] regv);
        if (mem_reg_write && mem_rd != 5'd0 && mem_rd == idx) return mem_result;
        if (wb_reg_write && wb_rd != 5'd0 && wb_rd == idx) return wb_result;
        return regv;
    endfunction

    always @(posedge clk or negedge rst_n or posedge preload_req) begin
        if (!rst_n) begin
            m     <= '0;
            m_cnt <= 16'h0;
        end else if (preload_req) begin
            m_cnt <= preload_val;
        end else if (flush) begin
            m <= '0;
        end else if (m_stall()) begin
            m     <= '0;
            m_cnt <= (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'h1;
        end else begin
            m.v    <= d_valid;
            m.pc   <= d_pc;
            m.r1d  <= d_rs1_data;
            m.r2d  <= d_rs2_data;
            m.imm  <= d_imm;
            m.rs1  <= d_rs1;
            m.rs2  <= d_rs2;
            m.rd   <= d_rd;
            m.alu  <= d_valid ? d_alu_cntrl : 4'h0;
            m.srcb <= d_valid && d_alu_src_b;
            m.rw   <= d_valid && d_reg_write;
            m.mw   <= d_valid && d_mem_write;
            m.rsrc <= d_valid ? d_result_src : 2'b00;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        assert_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("alu_a", alu_a, exp_fwd(m.rs1, m.r1d));
            check("alu_b", alu_b, m.srcb ? m.imm : exp_fwd(m.rs2, m.r2d));
            check("ex_store_data", ex_store_data, exp_fwd(m.rs2, m.r2d));
            check("ex_valid", ex_valid, m.v);
            check("ex_reg_write", ex_reg_write, m.rw);
            check("ex_mem_write", ex_mem_write, m.mw);
            check("ex_result_src", ex_result_src, m.rsrc);
            check("ex_rd", ex_rd, m.rd);
            check("ex_pc", ex_pc, m.pc);
            check("ex_alu_cntrl", ex_alu_cntrl, m.alu);
            check("stall_o", stall_o, m_stall());
            check("perf_bubbles", perf_bubbles, m_cnt);
        end
    end

    task automatic set_idle();
        d_valid = 0; d_pc = '0; d_rs1_data = '0; d_rs2_data = '0; d_imm = '0;
        d_rs1 = 0; d_rs2 = 0; d_rd = 0; d_alu_cntrl = 0; d_alu_src_b = 0;
        d_reg_write = 0; d_mem_write = 0; d_result_src = 0; flush = 0;
        mem_rd = 0; mem_reg_write = 0; mem_result = '0;
        wb_rd = 0; wb_reg_write = 0; wb_result = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_instr(input logic [4:0] rd);
        set_idle();
        d_valid = 1; d_reg_write = 1; d_result_src = 2'b01; d_rd = rd;
    endtask

    task automatic rand_inputs();
        d_valid      = ($urandom_range(0, 3) != 0);
        d_pc         = $urandom;
        d_rs1_data   = $urandom;
        d_rs2_data   = $urandom;
        d_imm        = $urandom;
        d_rs1        = 5'($urandom_range(0, 3));
        d_rs2        = 5'($urandom_range(0, 3));
        d_rd         = 5'($urandom_range(0, 3));
        d_alu_cntrl  = 4'($urandom);
        d_alu_src_b  = 1'($urandom);
        d_reg_write  = 1'($urandom);
        d_mem_write  = 1'($urandom);
        d_result_src = 2'($urandom);
        flush        = ($urandom_range(0, 7) == 0);
        mem_rd       = 5'($urandom_range(0, 3));
        mem_reg_write = 1'($urandom);
        mem_result   = $urandom;
        wb_rd        = 5'($urandom_range(0, 3));
        wb_reg_write = 1'($urandom);
        wb_result    = $urandom;
    endtask

    initial begin
        rst_n = 0;
        set_idle();
        mem_reg_write = 1; mem_result = 32'hFF;
        repeat (2) @(posedge clk);
        chk_en = 1;
        #1;
        check("rst_ex_valid", ex_valid, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_stall", stall_o, 0);
        check("rst_perf", perf_bubbles, 0);
        rst_n = 1;

        // Plain capture with immediate operand
        set_idle();
        d_valid = 1; d_rs1 = 1; d_rs2 = 2; d_rd = 4;
        d_rs1_data = 5; d_imm = 7; d_alu_src_b = 1; d_alu_cntrl = 0;
        step();
        set_idle();
        check("cap_alu_a", alu_a, 5);
        check("cap_alu_b", alu_b, 7);
        check("cap_alu_cntrl", ex_alu_cntrl, 0);
        check("cap_valid", ex_valid, 1);

        // Both forwarding sources match: EX/MEM wins
        set_idle();
        d_valid = 1; d_rs1 = 3; d_rs1_data = 32'h11;
        step();
        set_idle();
        mem_rd = 3; mem_result = 32'hAA; mem_reg_write = 1;
        wb_rd = 3;  wb_result = 32'hBB;  wb_reg_write = 1;
        #1 check("fwd_both", alu_a, 32'hAA);
        mem_reg_write = 0;
        #1 check("fwd_wb", alu_a, 32'hBB);

        // x0 is never forwarded
        set_idle();
        d_valid = 1; d_rs2 = 0; d_rs2_data = 0; d_alu_src_b = 0;
        step();
        set_idle();
        mem_rd = 0; mem_reg_write = 1; mem_result = 32'hFF;
        #1;
        check("x0_alu_b", alu_b, 0);
        check("x0_store", ex_store_data, 0);

        // Load-use stall
        load_instr(5);
        step();
        set_idle();
        d_valid = 1; d_rs1 = 5; d_rd = 6; d_reg_write = 1;
        #1 check("lu_stall", stall_o, 1);
        step();
        check("lu_bubble_valid", ex_valid, 0);
        check("lu_perf", perf_bubbles, 1);
        check("lu_stall_drop", stall_o, 0);
        step();
        check("lu_capture_valid", ex_valid, 1);
        check("lu_capture_rd", ex_rd, 6);

        // Flush overrides the stall condition
        load_instr(5);
        step();
        set_idle();
        d_valid = 1; d_rs2 = 5; flush = 1;
        #1 check("fl_stall", stall_o, 0);
        step();
        check("fl_valid", ex_valid, 0);
        check("fl_perf", perf_bubbles, 1);

        // Asynchronous reset in the middle of a stall
        load_instr(5);
        step();
        set_idle();
        d_valid = 1; d_rs1 = 5;
        #1 check("ar_stall_pre", stall_o, 1);
        rst_n = 0;
        #1;
        check("ar_valid", ex_valid, 0);
        check("ar_stall", stall_o, 0);
        check("ar_perf", perf_bubbles, 0);
        check("ar_alu_a", alu_a, 0);
        rst_n = 1;
        set_idle();
        step();

        // Counter saturation, preloaded near the top
        force dut.bubble_cnt_p1 = 16'hFFFE;
        preload_val = 16'hFFFE;
        preload_req = 1;
        #1;
        release dut.bubble_cnt_p1;
        preload_req = 0;
        check("sat_preload", perf_bubbles, 16'hFFFE);
        load_instr(5);
        d_rs1 = 5;
        step();
        check("sat_stall1", stall_o, 1);
        step();
        check("sat_perf1", perf_bubbles, 16'hFFFF);
        step();
        check("sat_stall2", stall_o, 1);
        step();
        check("sat_perf2", perf_bubbles, 16'hFFFF);

        // Randomized traffic with occasional mid-cycle reset pulses
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            if ($urandom_range(0, 199) == 0) begin
                #1 rst_n = 0;
                #1 rst_n = 1;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
